// File: rtl/ucsbece154b_icache_pkg.sv
// Shared types and default geometry for the instruction cache.
// FSM state encodings live here so the top and any debug tooling agree on them.
package ucsbece154b_icache_pkg;

    localparam int DEF_NUM_SETS    = 8;
    localparam int DEF_NUM_WAYS    = 4;
    localparam int DEF_BLOCK_WORDS = 4;
    localparam int DEF_WORD_SIZE   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FILL = 2'd3
    } icache_state_e;

    // Tag width left over once word-select, block offset and set index are removed.
    function automatic int tag_width(input int word_size, input int num_sets, input int block_words);
        return word_size - $clog2(num_sets) - $clog2(block_words) - 2;
    endfunction

endpackage

// File: rtl/ucsbece154b_icache_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// slave: the cache itself; master: whoever drives fetches and models memory.
interface ucsbece154b_icache_if #(
    parameter int WORD_SIZE = 32
);
    logic                 ReadEnable_i;
    logic [WORD_SIZE-1:0] ReadAddress_i;
    logic [WORD_SIZE-1:0] Instruction_o;
    logic                 Ready_o;
    logic [WORD_SIZE-1:0] MemReadAddress_o;
    logic                 MemReadRequest_o;
    logic [WORD_SIZE-1:0] MemDataIn_i;
    logic                 MemDataReady_i;

    modport slave (
        input  ReadEnable_i, ReadAddress_i, MemDataIn_i, MemDataReady_i,
        output Instruction_o, Ready_o, MemReadAddress_o, MemReadRequest_o
    );

    modport master (
        output ReadEnable_i, ReadAddress_i, MemDataIn_i, MemDataReady_i,
        input  Instruction_o, Ready_o, MemReadAddress_o, MemReadRequest_o
    );
endinterface

// File: rtl/ucsbece154b_icache_way.sv
// One cache way: valid/tag/data arrays, combinational lookup, whole-line write port.
// Only the valid bits are reset; tags and data are qualified by valid.
module ucsbece154b_icache_way
    import ucsbece154b_icache_pkg::*;
#(
    parameter int NUM_SETS    = DEF_NUM_SETS,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int TAG_W       = tag_width(DEF_WORD_SIZE, DEF_NUM_SETS, DEF_BLOCK_WORDS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [$clog2(NUM_SETS)-1:0]      rd_index_i,
    input  logic [TAG_W-1:0]                 rd_tag_i,
    input  logic [$clog2(BLOCK_WORDS)-1:0]   rd_offset_i,
    output logic                             hit_o,
    output logic [WORD_SIZE-1:0]             rd_word_o,
    input  logic [$clog2(NUM_SETS)-1:0]      wr_index_i,
    output logic                             wr_valid_o,
    input  logic                             wr_en_i,
    input  logic [TAG_W-1:0]                 wr_tag_i,
    input  logic [BLOCK_WORDS*WORD_SIZE-1:0] wr_block_i
);

    logic [NUM_SETS-1:0]  valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_SETS];
    logic [WORD_SIZE-1:0] data_q [NUM_SETS][BLOCK_WORDS];

    // Valid bits: cleared by reset, set when a line is installed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag and data storage, written as a whole line during fill.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i] <= wr_tag_i;
            for (int w = 0; w < BLOCK_WORDS; w++) begin
                data_q[wr_index_i][w] <= wr_block_i[w*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    assign hit_o      = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);
    assign rd_word_o  = data_q[rd_index_i][rd_offset_i];
    assign wr_valid_o = valid_q[wr_index_i];

endmodule

// File: rtl/ucsbece154b_icache.sv
// Set-associative read-only instruction cache with word-serial block refill.
// Optional build macro ICACHE_EARLY_RESTART_EN: forward the missed word straight
// from the memory port in the beat it arrives, if the fetch is still for it.
//
// state | meaning
// IDLE  | combinational lookup; hit or idle -> Ready_o=1, miss -> capture address
// REQ   | one-cycle MemReadRequest_o pulse for the captured block
// WAIT  | collect BLOCK_WORDS beats into the refill buffer
// FILL  | install buffer into victim way, advance round-robin pointer if used
module ucsbece154b_icache
    import ucsbece154b_icache_pkg::*;
#(
    parameter int NUM_SETS    = DEF_NUM_SETS,
    parameter int NUM_WAYS    = DEF_NUM_WAYS,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int WORD_SIZE   = DEF_WORD_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    ucsbece154b_icache_if.slave    bus
);

    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int TAG_W = tag_width(WORD_SIZE, NUM_SETS, BLOCK_WORDS);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);

    icache_state_e state_q, state_d;
    logic [WORD_SIZE-3:0] miss_word_q;
    logic [OFF_W-1:0]     cnt_q;
    logic [WORD_SIZE-1:0] buf_q [BLOCK_WORDS];
    logic [WAY_W-1:0]     rr_q  [NUM_SETS];

    logic [OFF_W-1:0] rd_off;
    logic [IDX_W-1:0] rd_idx, miss_idx;
    logic [TAG_W-1:0] rd_tag, miss_tag;

    assign rd_off   = bus.ReadAddress_i[OFF_W+1:2];
    assign rd_idx   = bus.ReadAddress_i[OFF_W+2 +: IDX_W];
    assign rd_tag   = bus.ReadAddress_i[WORD_SIZE-1 -: TAG_W];
    assign miss_idx = miss_word_q[OFF_W +: IDX_W];
    assign miss_tag = miss_word_q[WORD_SIZE-3 -: TAG_W];

    logic [NUM_WAYS-1:0]  way_hit, way_wvalid, way_we;
    logic [WORD_SIZE-1:0] way_word [NUM_WAYS];
    logic [BLOCK_WORDS*WORD_SIZE-1:0] fill_block;

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
        ucsbece154b_icache_way #(
            .NUM_SETS(NUM_SETS), .BLOCK_WORDS(BLOCK_WORDS),
            .WORD_SIZE(WORD_SIZE), .TAG_W(TAG_W)
        ) u_way (
            .clk(clk), .reset(reset),
            .rd_index_i(rd_idx), .rd_tag_i(rd_tag), .rd_offset_i(rd_off),
            .hit_o(way_hit[g]), .rd_word_o(way_word[g]),
            .wr_index_i(miss_idx), .wr_valid_o(way_wvalid[g]),
            .wr_en_i(way_we[g]), .wr_tag_i(miss_tag), .wr_block_i(fill_block)
        );
    end

    logic                 hit;
    logic [WORD_SIZE-1:0] hit_word;
    logic [WAY_W-1:0]     victim;
    logic                 victim_from_rr;

    // Hit mux across ways; at most one way can match a given tag.
    always_comb begin
        hit      = 1'b0;
        hit_word = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (way_hit[w]) begin
                hit      = 1'b1;
                hit_word = way_word[w];
            end
        end
    end

    // Victim: lowest invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        victim         = rr_q[miss_idx];
        victim_from_rr = 1'b1;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!way_wvalid[w]) begin
                victim         = WAY_W'(w);
                victim_from_rr = 1'b0;
            end
        end
    end

    // Flatten the refill buffer and steer the line write to the victim.
    always_comb begin
        fill_block = '0;
        way_we     = '0;
        for (int w = 0; w < BLOCK_WORDS; w++) begin
            fill_block[w*WORD_SIZE +: WORD_SIZE] = buf_q[w];
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            way_we[w] = (state_q == ST_FILL) && (victim == WAY_W'(w));
        end
    end

    logic                 ready_c, req_c, capture;
    logic [WORD_SIZE-1:0] instr_c;

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        req_c   = 1'b0;
        capture = 1'b0;
        instr_c = hit_word;
        case (state_q)
            ST_IDLE: begin
                if (!bus.ReadEnable_i || hit) begin
                    ready_c = 1'b1;
                end else begin
                    capture = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                req_c   = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
`ifdef ICACHE_EARLY_RESTART_EN
                if (bus.MemDataReady_i && (cnt_q == miss_word_q[OFF_W-1:0]) &&
                    bus.ReadEnable_i && (bus.ReadAddress_i[WORD_SIZE-1:2] == miss_word_q)) begin
                    ready_c = 1'b1;
                    instr_c = bus.MemDataIn_i;
                end
`endif
                if (bus.MemDataReady_i && (cnt_q == LAST_BEAT)) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state: FSM, captured miss address, beat counter, replacement pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            miss_word_q <= '0;
            cnt_q       <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (capture) begin
                miss_word_q <= bus.ReadAddress_i[WORD_SIZE-1:2];
            end
            if (state_q == ST_WAIT && bus.MemDataReady_i) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == ST_FILL && victim_from_rr) begin
                rr_q[miss_idx] <= rr_q[miss_idx] + 1'b1;
            end
        end
    end

    // Refill buffer; contents are only consumed in FILL after a complete refill.
    always_ff @(posedge clk) begin
        if (state_q == ST_WAIT && bus.MemDataReady_i) begin
            buf_q[cnt_q] <= bus.MemDataIn_i;
        end
    end

    assign bus.Ready_o          = reset & ready_c;
    assign bus.Instruction_o    = instr_c;
    assign bus.MemReadRequest_o = req_c;
    assign bus.MemReadAddress_o = {miss_word_q[WORD_SIZE-3:OFF_W], {(OFF_W+2){1'b0}}};

    // Byte-select bits are never used; the miss offset only matters with early restart.
    logic unused_bits;
`ifdef ICACHE_EARLY_RESTART_EN
    assign unused_bits = ^bus.ReadAddress_i[1:0];
`else
    assign unused_bits = ^{bus.ReadAddress_i[1:0], miss_word_q[OFF_W-1:0]};
`endif

endmodule

// File: tb/tb_ucsbece154b_icache.sv
module tb_ucsbece154b_icache;

    localparam int BW = 4;
`ifdef ICACHE_EARLY_RESTART_EN
    localparam bit ER = 1'b1;
`else
    localparam bit ER = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ucsbece154b_icache_if bus ();
    ucsbece154b_icache dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_instr_q [$];
    logic [31:0] exp_req_q   [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h10) >> 2);
    endfunction

    // Ready-low cycles from the request pulse until the fetch is served.
    function automatic int miss_lows(input logic [31:0] a);
        return ER ? (1 + int'(a[3:2])) : (2 + BW);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: instruction responses and refill requests.
    always @(negedge clk) begin
        if (reset && bus.ReadEnable_i && bus.Ready_o) begin
            if (exp_instr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_response: addr 0x%08h got 0x%08h, expected none",
                         bus.ReadAddress_i, bus.Instruction_o);
            end else begin
                check("instruction", bus.Instruction_o, exp_instr_q.pop_front());
            end
        end
        if (reset && bus.MemReadRequest_o) begin
            if (exp_req_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_request: got addr 0x%08h, expected none", bus.MemReadAddress_o);
            end else begin
                check("refill_address", bus.MemReadAddress_o, exp_req_q.pop_front());
            end
        end
    end

    // Memory model: one beat per cycle starting the cycle after the request.
    initial begin
        logic [31:0] base;
        bus.MemDataReady_i = 1'b0;
        bus.MemDataIn_i    = '0;
        forever begin
            @(negedge clk);
            if (reset && bus.MemReadRequest_o) begin
                base = bus.MemReadAddress_o;
                for (int i = 0; i < BW; i++) begin
                    @(posedge clk); #1;
                    if (!reset) begin
                        bus.MemDataReady_i = 1'b0;
                        break;
                    end
                    bus.MemDataReady_i = 1'b1;
                    bus.MemDataIn_i    = mem_word(base + 32'(4 * i));
                end
                @(posedge clk); #1;
                bus.MemDataReady_i = 1'b0;
            end
        end
    end

    task automatic fetch(input logic [31:0] addr, input bit exp_req, input int exp_lows, input string name);
        int lows = 0;
        int n = 0;
        bit started = 0;
        bit ok = 0;
        exp_instr_q.push_back(mem_word(addr));
        if (exp_req) exp_req_q.push_back({addr[31:4], 4'h0});
        bus.ReadEnable_i  = 1'b1;
        bus.ReadAddress_i = addr;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (bus.Ready_o) begin
                ok = 1;
                break;
            end
            if (bus.MemReadRequest_o) started = 1;
            if (!exp_req || started) lows++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no Ready_o for addr 0x%08h within 60 cycles", name, addr);
        end else begin
            check({name, "_stall"}, 32'(lows), 32'(exp_lows));
        end
        @(posedge clk); #1;
        bus.ReadEnable_i = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.ReadEnable_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_request(input string name);
        int n = 0;
        while (n < 20 && !bus.MemReadRequest_o) begin
            @(negedge clk);
            n++;
        end
        if (!bus.MemReadRequest_o) begin
            checks++; errors++;
            $display("FAIL %s_no_request: got no MemReadRequest_o, expected one", name);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ReadEnable_i  = 1'b0;
        bus.ReadAddress_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(bus.Ready_o), 32'd0);
        check("reset_request", 32'(bus.MemReadRequest_o), 32'd0);
        check("reset_address", bus.MemReadAddress_o, 32'h0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", 32'(bus.Ready_o), 32'd1);

        // Cold miss then the rest of the line.
        fetch(32'h10, 1, miss_lows(32'h10), "cold");
        fetch(32'h14, 0, ER ? 4 : 0, "cold_next");
        fetch(32'h18, 0, 0, "hit_18");
        fetch(32'h1C, 0, 0, "hit_1c");
        fetch(32'h10, 0, 0, "hit_10");

        // Set 1 fills ways 1..3, then 0x210 evicts 0x010.
        fetch(32'h090, 1, miss_lows(32'h090), "fill_w1"); idle(6);
        fetch(32'h110, 1, miss_lows(32'h110), "fill_w2"); idle(6);
        fetch(32'h190, 1, miss_lows(32'h190), "fill_w3"); idle(6);
        fetch(32'h210, 1, miss_lows(32'h210), "evict_w0"); idle(6);
        fetch(32'h094, 0, 0, "keep_090");
        fetch(32'h010, 1, miss_lows(32'h010), "refetch_010"); idle(6);
        fetch(32'h110, 0, 0, "keep_110");
        fetch(32'h190, 0, 0, "keep_190");
        fetch(32'h214, 0, 0, "keep_210");
        fetch(32'h098, 1, miss_lows(32'h098), "evict_090"); idle(6);

        // Redirect to a cached address while the 0x40 refill is in flight.
        exp_req_q.push_back(32'h40);
        bus.ReadEnable_i  = 1'b1;
        bus.ReadAddress_i = 32'h40;
        wait_request("redirect");
        fetch(32'h10, 0, BW + 1, "redirect");
        fetch(32'h40, 0, 0, "redirect_line");
        fetch(32'h4C, 0, 0, "redirect_line_end");

        // Miss at a mid-line offset.
        fetch(32'h58, 1, miss_lows(32'h58), "mid_offset");
        fetch(32'h5C, 0, ER ? 2 : 0, "mid_offset_next");
        fetch(32'h50, 0, 0, "mid_offset_base");
        idle(2);
        check("idle_ready_2", 32'(bus.Ready_o), 32'd1);

        // Asynchronous reset after two refill beats.
        exp_req_q.push_back(32'h20);
        bus.ReadEnable_i  = 1'b1;
        bus.ReadAddress_i = 32'h20;
        wait_request("reset_mid");
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset_request", 32'(bus.MemReadRequest_o), 32'd0);
        check("midreset_ready", 32'(bus.Ready_o), 32'd0);
        check("midreset_address", bus.MemReadAddress_o, 32'h0);
        bus.ReadEnable_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("postreset_ready", 32'(bus.Ready_o), 32'd1);
        fetch(32'h20, 1, miss_lows(32'h20), "refetch_20"); idle(6);
        fetch(32'h094, 1, miss_lows(32'h094), "invalidated_090"); idle(6);

        idle(4);
        check("pending_responses", 32'(exp_instr_q.size()), 32'd0);
        check("pending_requests", 32'(exp_req_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ucsbece154b_icache.md
Name: ucsbece154b_icache

Overview:
- Set-associative, read-only instruction cache between the fetch stage and instruction memory.
- Returns the instruction with Ready_o=1 in the same cycle on a hit. The pipeline controller uses this signal as Ready_F and stalls F/D while it is low.
- On a miss, runs a block refill from a word-serial memory port, installs the line, then serves the fetch.

Parameters:
- NUM_SETS, 8, number of sets (power of 2).
- NUM_WAYS, 4, associativity (power of 2).
- BLOCK_WORDS, 4, 32-bit words per line (power of 2).
- WORD_SIZE, 32, data/address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- ReadEnable_i  input  1  fetch request valid.
- ReadAddress_i  input  32  byte address of fetch (PCF); bits[1:0] ignored.
- Instruction_o  output  32  instruction word for ReadAddress_i.
- Ready_o  output  1  1 = Instruction_o valid / no stall needed.
- MemReadAddress_o  output  32  block-aligned refill address.
- MemReadRequest_o  output  1  one-cycle refill request pulse.
- MemDataIn_i  input  32  refill data word.
- MemDataReady_i  input  1  MemDataIn_i valid this cycle. Words arrive in ascending order from block base, at most one per cycle.

Behaviour:
- Address split: offset = addr[log2(BLOCK_WORDS)+1:2]; index = next log2(NUM_SETS) bits; tag = remaining upper bits.
- Per way/set: valid bit, tag, BLOCK_WORDS data words. Per set: round-robin replacement pointer, log2(NUM_WAYS) bits.
- Reset (async, reset=0): state=IDLE, all valid=0, all replacement pointers=0, word counter=0, MemReadRequest_o=0, MemReadAddress_o=0, Ready_o=0 while in reset. Data/tag arrays are not reset.
- IDLE, hit detection is combinational:
  - ReadEnable_i=0 -> Ready_o=1, Instruction_o=don't care.
  - ReadEnable_i=1 and hit (valid & tag match in indexed set) -> Ready_o=1, Instruction_o=hit word, zero latency.
  - ReadEnable_i=1 and miss -> Ready_o=0. Capture block-aligned miss address. Next state REQ.
- REQ: MemReadRequest_o=1 for exactly one cycle; MemReadAddress_o=captured address. Ready_o=0. -> WAIT.
- WAIT:
  - Each cycle MemDataReady_i=1: store word into refill buffer[counter], counter++.
  - When counter reaches BLOCK_WORDS-1 and MemDataReady_i=1 -> FILL.
  - MemReadAddress_o holds its value. Ready_o=0.
- FILL (one cycle):
  - Victim way = lowest-numbered invalid way in the set, else the set's replacement pointer.
  - Write buffer, tag, valid=1 into the victim way.
  - If the victim came from the replacement pointer, pointer <= pointer+1, wrapping mod NUM_WAYS.
  - Ready_o=0. -> IDLE. The retried fetch hits the next cycle.
- Miss penalty without the optional feature: 1 (REQ) + BLOCK_WORDS memory beats + 1 (FILL) + 1 hit cycle.
- ReadAddress_i changing during a refill (redirect / FlushD): the refill completes for the captured address. In IDLE the new address is looked up fresh. A refill is never aborted except by reset.
- Reset asserted mid-refill: immediate return to IDLE, partial buffer discarded, no line written.
- MemDataReady_i outside WAIT: ignored.
- Two misses to the same set fill different ways until all ways are valid, then round-robin applies.

Optional Feature:
- Macro: ICACHE_EARLY_RESTART_EN.
- Defined:
  - In WAIT, when the beat whose index equals the captured miss offset arrives, ReadAddress_i still equals the captured address, and ReadEnable_i=1: Ready_o=1 and Instruction_o=MemDataIn_i in that same cycle.
  - Any other request during WAIT/FILL: Ready_o=0.
  - Refill continues to completion unchanged.
- Undefined: Ready_o=0 throughout REQ/WAIT/FILL, as above.

Decomposition:
- Shared defines header (ucsbece154b_defines.vh): FSM state encodings (IDLE, REQ, WAIT, FILL) and derived widths (offset, index, tag, way-index).
- Natural sub-module: ucsbece154b_icache_way, one way's valid/tag/data arrays with combinational lookup and write port, instantiated NUM_WAYS times.

Test Plan:
- Cold miss: reset release, ReadEnable_i=1, ReadAddress_i=0x0000_0010, memory returns 0xA0,0xA1,0xA2,0xA3 on consecutive cycles -> one MemReadRequest_o pulse with MemReadAddress_o=0x10; Ready_o=0 for 6 cycles; then Ready_o=1, Instruction_o=0xA0. Address 0x14 next cycle -> immediate hit, 0xA1.
- Hit after fill for all four offsets 0x10..0x1C -> Ready_o=1 each cycle, no MemReadRequest_o.
- Replacement: five misses to distinct tags mapping to set 1 (stride 0x80: 0x010, 0x090, 0x110, 0x190, 0x210) -> ways 0..3 filled, fifth evicts way 0. Re-access 0x010 misses; 0x090 still hits.
- Redirect mid-refill: miss on 0x40, during WAIT switch ReadAddress_i to 0x10 (cached) -> Ready_o stays 0 until FILL completes; 0x40 line installed; 0x10 hits in the following IDLE cycle.
- Async reset mid-WAIT after 2 beats -> MemReadRequest_o=0, state IDLE. Re-fetch of the same address misses and issues a new request.
- With ICACHE_EARLY_RESTART_EN, miss on 0x18 (offset 2) -> Ready_o=1 with Instruction_o=third beat in the same cycle it arrives; Ready_o=0 for the remaining beat and FILL.
